// File: rtl/spmm_pkg.sv
// Shared types and defaults for the sparse x dense row engine.
package spmm_pkg;

    localparam int DEF_DW    = 32;
    localparam int DEF_AW    = 64;
    localparam int DEF_LANES = 2;
    localparam int DEF_RW    = 10;
    localparam int DEF_CW    = 10;
    localparam int DEF_NROWS = 560;

    // S_EMIT/S_ZFILL close rows ahead of the pending entry.
    // S_EMIT_TAIL/S_ZFILL_TAIL flush the matrix through row NROWS-1.
    typedef enum logic [3:0] {
        S_IDLE,
        S_ACCEPT,
        S_FETCH,
        S_WAIT,
        S_MUL,
        S_ACC,
        S_EMIT,
        S_ZFILL,
        S_EMIT_TAIL,
        S_ZFILL_TAIL,
        S_DONE
    } state_t;

    // Bit offset of a lane inside a packed multi-lane bus.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/spmm_row_engine_if.sv
// Handshake bundle between the row engine and its environment.
// slave = engine side, master = environment (stream source, dense memory, sink).
interface spmm_row_engine_if
    import spmm_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int AW    = DEF_AW,
    parameter int LANES = DEF_LANES,
    parameter int RW    = DEF_RW,
    parameter int CW    = DEF_CW
) ();

    logic                  start;
    logic                  nz_valid;
    logic                  nz_ready;
    logic [RW-1:0]         nz_row;
    logic [CW-1:0]         nz_col;
    logic [DW-1:0]         nz_val;
    logic                  nz_last;
    logic                  req_valid;
    logic                  req_ready;
    logic [CW-1:0]         req_addr;
    logic                  rsp_valid;
    logic [LANES*DW-1:0]   rsp_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [RW-1:0]         out_row;
    logic [LANES*AW-1:0]   out_data;
    logic                  out_zero;
    logic                  out_last;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport slave (
        input  start, nz_valid, nz_row, nz_col, nz_val, nz_last,
        input  req_ready, rsp_valid, rsp_data, out_ready,
        output nz_ready, req_valid, req_addr,
        output out_valid, out_row, out_data, out_zero, out_last,
        output busy, done, err
    );

    modport master (
        output start, nz_valid, nz_row, nz_col, nz_val, nz_last,
        output req_ready, rsp_valid, rsp_data, out_ready,
        input  nz_ready, req_valid, req_addr,
        input  out_valid, out_row, out_data, out_zero, out_last,
        input  busy, done, err
    );

endinterface

// File: rtl/spmm_lane_mac.sv
// One lane of the engine: registered signed DWxDW product, then a
// wrap-around AW-bit accumulator with clear taking priority over add.
module spmm_lane_mac
    import spmm_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          mul_en,
    input  logic          acc_en,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [AW-1:0] acc
);

    logic signed [2*DW-1:0] a_ext;
    logic signed [2*DW-1:0] b_ext;
    logic signed [2*DW-1:0] prod_q;

    assign a_ext = (2*DW)'($signed(a));
    assign b_ext = (2*DW)'($signed(b));

    // Product stage then accumulate stage; the product is sign-extended to AW.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prod_q <= '0;
            acc    <= '0;
        end else begin
            if (mul_en) begin
                prod_q <= a_ext * b_ext;
            end
            if (clr) begin
                acc <= '0;
            end else if (acc_en) begin
                acc <= acc + AW'(prod_q);
            end
        end
    end

endmodule

// File: rtl/spmm_row_engine.sv
// Row-wise sparse x dense multiply: walks a row-sorted COO stream, fetches one
// dense row per nonzero, accumulates per lane and emits every output row in order.
module spmm_row_engine
    import spmm_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int AW    = DEF_AW,
    parameter int LANES = DEF_LANES,
    parameter int RW    = DEF_RW,
    parameter int CW    = DEF_CW,
    parameter int NROWS = DEF_NROWS
) (
    input  logic             clk,
    input  logic             rst,
    spmm_row_engine_if.slave bus
);

    localparam int            RW1      = RW + 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(NROWS - 1);
    localparam logic [RW:0]   NROWS_W  = RW1'(NROWS);

    state_t state;
    state_t state_nxt;

    logic [RW-1:0]       cur_row;
    logic [RW-1:0]       row_inc;
    logic [RW-1:0]       pend_row;
    logic [CW-1:0]       pend_col;
    logic [DW-1:0]       pend_val;
    logic                pend_last;
    logic                has_nz;
    logic                err_q;
    logic [LANES*DW-1:0] dense_q;
    logic [LANES*AW-1:0] acc_all;

    logic row_bad;
    logic row_same;
    logic at_last;
    logic nz_hs;
    logic out_hs;
    logic nz_ready;
    logic req_valid;
    logic out_valid;
    logic busy;
    logic done;
    logic mac_clr;
    logic mul_en;
    logic acc_en;

    assign row_bad  = ({1'b0, bus.nz_row} >= NROWS_W) || (bus.nz_row < cur_row);
    assign row_same = (bus.nz_row == cur_row);
    assign at_last  = (cur_row == LAST_ROW);
    assign row_inc  = cur_row + RW'(1);
    assign nz_hs    = nz_ready && bus.nz_valid;
    assign out_hs   = out_valid && bus.out_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and the state-derived handshake/status outputs.
    always_comb begin
        state_nxt = state;
        nz_ready  = 1'b0;
        req_valid = 1'b0;
        out_valid = 1'b0;
        busy      = (state != S_IDLE);
        done      = 1'b0;
        mul_en    = 1'b0;
        acc_en    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                nz_ready = 1'b1;
                if (bus.nz_valid) begin
                    if (row_bad) begin
                        state_nxt = bus.nz_last ? S_EMIT_TAIL : S_ACCEPT;
                    end else if (row_same) begin
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_EMIT;
                    end
                end
            end
            S_FETCH: begin
                req_valid = 1'b1;
                if (bus.req_ready) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.rsp_valid) begin
                    state_nxt = S_MUL;
                end
            end
            S_MUL: begin
                mul_en    = 1'b1;
                state_nxt = S_ACC;
            end
            S_ACC: begin
                acc_en    = 1'b1;
                state_nxt = pend_last ? S_EMIT_TAIL : S_ACCEPT;
            end
            S_EMIT: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = (row_inc < pend_row) ? S_ZFILL : S_FETCH;
                end
            end
            S_ZFILL: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = (row_inc == pend_row) ? S_FETCH : S_ZFILL;
                end
            end
            S_EMIT_TAIL, S_ZFILL_TAIL: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = at_last ? S_DONE : S_ZFILL_TAIL;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign mac_clr = ((state == S_IDLE) && bus.start) || out_hs;

    // Pass bookkeeping: current row, captured entry, dense row, sticky error.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_row   <= '0;
            pend_row  <= '0;
            pend_col  <= '0;
            pend_val  <= '0;
            pend_last <= 1'b0;
            has_nz    <= 1'b0;
            err_q     <= 1'b0;
            dense_q   <= '0;
        end else begin
            if ((state == S_IDLE) && bus.start) begin
                cur_row <= '0;
                has_nz  <= 1'b0;
            end
            if (nz_hs) begin
                pend_row  <= bus.nz_row;
                pend_col  <= bus.nz_col;
                pend_val  <= bus.nz_val;
                pend_last <= bus.nz_last;
                if (row_bad) begin
                    err_q <= 1'b1;
                end
            end
            if (bus.rsp_valid) begin
                if (state == S_WAIT) begin
                    dense_q <= bus.rsp_data;
                end else begin
                    err_q <= 1'b1;
                end
            end
            if (acc_en) begin
                has_nz <= 1'b1;
            end
            if (out_hs) begin
                has_nz <= 1'b0;
                if (!at_last) begin
                    cur_row <= row_inc;
                end
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        localparam int DLO = lane_lsb(g, DW);
        localparam int ALO = lane_lsb(g, AW);
        spmm_lane_mac #(
            .DW(DW),
            .AW(AW)
        ) u_mac (
            .clk    (clk),
            .rst    (rst),
            .clr    (mac_clr),
            .mul_en (mul_en),
            .acc_en (acc_en),
            .a      (pend_val),
            .b      (dense_q[DLO +: DW]),
            .acc    (acc_all[ALO +: AW])
        );
    end

    assign bus.nz_ready  = nz_ready;
    assign bus.req_valid = req_valid;
    assign bus.req_addr  = req_valid ? pend_col : '0;
    assign bus.out_valid = out_valid;
    assign bus.out_row   = out_valid ? cur_row : '0;
    assign bus.out_data  = out_valid ? acc_all : '0;
    assign bus.out_zero  = out_valid && !has_nz;
    assign bus.out_last  = out_valid && at_last;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_spmm_row_engine.sv
// Directed bench for spmm_row_engine (LANES=2, NROWS=4) with an output-row scoreboard.
module tb_spmm_row_engine;

    localparam int DW    = 32;
    localparam int AW    = 64;
    localparam int LANES = 2;
    localparam int RW    = 10;
    localparam int CW    = 10;
    localparam int NROWS = 4;

    typedef struct {
        logic [RW-1:0]       row;
        logic [LANES*AW-1:0] data;
        logic                zero;
        logic                last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int   rsp_lat    = 0;
    int   req_stall  = 0;
    bit   rsp_enable = 1'b1;
    bit   in_wait    = 1'b0;
    bit   resp_busy  = 1'b0;
    logic [LANES*DW-1:0] dense_mem [16];

    always #5 clk = ~clk;

    spmm_row_engine_if #(.DW(DW), .AW(AW), .LANES(LANES), .RW(RW), .CW(CW)) bus ();

    spmm_row_engine #(
        .DW(DW), .AW(AW), .LANES(LANES), .RW(RW), .CW(CW), .NROWS(NROWS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [LANES*DW-1:0] pack2(input int l0, input int l1);
        return {l1, l0};
    endfunction

    task automatic push_row(input int row, input longint d0, input longint d1,
                            input logic zero, input logic last);
        exp_t e;
        e.row  = RW'(row);
        e.data = {d1, d0};
        e.zero = zero;
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic start_pass();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Offer one COO entry and hold it until the engine takes it.
    task automatic apply_stimulus(input int row, input int col, input int val, input logic last);
        int n = 0;
        @(negedge clk);
        bus.nz_valid = 1'b1;
        bus.nz_row   = RW'(row);
        bus.nz_col   = CW'(col);
        bus.nz_val   = val;
        bus.nz_last  = last;
        #2;
        while (bus.nz_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            #2;
            n++;
        end
        check_output("nz_accept", 128'(bus.nz_ready), 128'(1));
        @(negedge clk);
        bus.nz_valid = 1'b0;
        bus.nz_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        @(negedge clk);
        #2;
        while (bus.done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            #2;
            n++;
        end
        check_output({tag, "_done"}, 128'(bus.done), 128'(1));
        check_output({tag, "_drained"}, 128'(exp_q.size()), 128'(0));
        @(negedge clk);
        #2;
        check_output({tag, "_idle"}, 128'({bus.busy, bus.done}), 128'(0));
    endtask

    task automatic check_reset(input string tag);
        check_output({tag, "_flags"},
                     128'({bus.out_valid, bus.out_zero, bus.out_last, bus.nz_ready,
                           bus.req_valid, bus.busy, bus.done, bus.err}), 128'(0));
        check_output({tag, "_data"}, 128'(bus.out_data), 128'(0));
        check_output({tag, "_row_addr"}, 128'({bus.out_row, bus.req_addr}), 128'(0));
    endtask

    task automatic run_single(input string tag);
        dense_mem[3] = pack2(5, -7);
        push_row(0, 10, -14, 1'b0, 1'b0);
        push_row(1, 0, 0, 1'b1, 1'b0);
        push_row(2, 0, 0, 1'b1, 1'b0);
        push_row(3, 0, 0, 1'b1, 1'b1);
        start_pass();
        apply_stimulus(0, 3, 2, 1'b1);
        wait_done(tag);
    endtask

    task automatic run_two(input string tag);
        dense_mem[0] = pack2(1, 1);
        dense_mem[1] = pack2(2, -1);
        push_row(0, 0, 0, 1'b1, 1'b0);
        push_row(1, 11, -1, 1'b0, 1'b0);
        push_row(2, 0, 0, 1'b1, 1'b0);
        push_row(3, 0, 0, 1'b1, 1'b1);
        start_pass();
        apply_stimulus(1, 0, 3, 1'b0);
        apply_stimulus(1, 1, 4, 1'b1);
        wait_done(tag);
    endtask

    // Dense-row memory: optional req_ready stall, then one response after rsp_lat cycles.
    initial begin : responder
        logic [CW-1:0] addr;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = '0;
        forever begin
            @(negedge clk);
            bus.rsp_valid = 1'b0;
            if (bus.req_valid === 1'b1) begin
                resp_busy = 1'b1;
                for (int i = 0; i < req_stall; i++) @(negedge clk);
                bus.req_ready = 1'b1;
                addr = bus.req_addr;
                @(negedge clk);
                bus.req_ready = 1'b0;
                in_wait = 1'b1;
                for (int i = 0; i < rsp_lat; i++) @(negedge clk);
                in_wait = 1'b0;
                if (rsp_enable) begin
                    bus.rsp_data  = dense_mem[addr[3:0]];
                    bus.rsp_valid = 1'b1;
                end
                resp_busy = 1'b0;
            end
        end
    end

    // Scoreboard: every output handshake pops and checks one expected row.
    always begin : monitor
        exp_t e;
        @(negedge clk);
        #2;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            check_output("row_expected", 128'(exp_q.size() != 0), 128'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_output("out_row", 128'(bus.out_row), 128'(e.row));
                check_output("out_data", 128'(bus.out_data), 128'(e.data));
                check_output("out_zero", 128'(bus.out_zero), 128'(e.zero));
                check_output("out_last", 128'(bus.out_last), 128'(e.last));
            end
        end
    end

    initial begin : stimulus
        int n;
        logic [LANES*AW-1:0] hold_exp;
        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.nz_valid  = 1'b0;
        bus.nz_row    = '0;
        bus.nz_col    = '0;
        bus.nz_val    = '0;
        bus.nz_last   = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) dense_mem[i] = '0;

        repeat (3) @(negedge clk);
        #2;
        check_reset("reset");
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] single nonzero in row 0, zero-fill to the end");
        run_single("t1");

        $display("[TB] two nonzeros in row 1");
        run_two("t2");

        $display("[TB] output backpressure during a row emit");
        dense_mem[0] = pack2(1, 1);
        dense_mem[1] = pack2(2, -1);
        push_row(0, 4, -2, 1'b0, 1'b0);
        push_row(1, 0, 0, 1'b1, 1'b0);
        push_row(2, 3, 3, 1'b0, 1'b0);
        push_row(3, 0, 0, 1'b1, 1'b1);
        start_pass();
        apply_stimulus(0, 1, 2, 1'b0);
        bus.out_ready = 1'b0;
        apply_stimulus(2, 0, 3, 1'b1);
        n = 0;
        @(negedge clk);
        #2;
        while (bus.out_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            #2;
            n++;
        end
        check_output("t3_out_valid", 128'(bus.out_valid), 128'(1));
        hold_exp = {64'hFFFF_FFFF_FFFF_FFFE, 64'd4};
        for (int c = 0; c < 5; c++) begin
            check_output("t3_hold_row", 128'(bus.out_row), 128'(0));
            check_output("t3_hold_data", 128'(bus.out_data), 128'(hold_exp));
            check_output("t3_hold_zero", 128'(bus.out_zero), 128'(0));
            check_output("t3_no_accept", 128'(bus.nz_ready), 128'(0));
            check_output("t3_no_fetch", 128'(bus.req_valid), 128'(0));
            @(negedge clk);
            #2;
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        wait_done("t3");

        $display("[TB] slow memory: 20-cycle response, 7-cycle request stall");
        rsp_lat   = 20;
        req_stall = 7;
        run_two("t5");
        rsp_lat   = 0;
        req_stall = 0;
        check_output("err_clean", 128'(bus.err), 128'(0));

        $display("[TB] out-of-order entry carrying last");
        dense_mem[0] = pack2(32'h8000_0000, 0);
        push_row(0, 0, 0, 1'b1, 1'b0);
        push_row(1, 0, 0, 1'b1, 1'b0);
        push_row(2, 64'sh8000_0000, 0, 1'b0, 1'b0);
        push_row(3, 0, 0, 1'b1, 1'b1);
        start_pass();
        apply_stimulus(2, 0, -1, 1'b0);
        apply_stimulus(1, 0, 5, 1'b1);
        wait_done("t4");
        check_output("t4_err", 128'(bus.err), 128'(1));

        $display("[TB] reset while waiting for a dense row");
        rsp_lat = 20;
        start_pass();
        apply_stimulus(0, 3, 2, 1'b1);
        n = 0;
        while (!in_wait && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_output("t6_reached_wait", 128'(in_wait), 128'(1));
        repeat (3) @(negedge clk);
        rsp_enable = 1'b0;
        rst        = 1'b0;
        @(negedge clk);
        #2;
        check_reset("t6_reset");
        n = 0;
        while (resp_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_output("t6_mem_quiet", 128'(resp_busy), 128'(0));
        @(negedge clk);
        rst        = 1'b1;
        rsp_enable = 1'b1;
        rsp_lat    = 0;
        repeat (3) @(negedge clk);
        #2;
        check_output("t6_no_rows", 128'({bus.out_valid, bus.busy}), 128'(0));
        run_single("t6_rerun");
        check_output("t6_err_clear", 128'(bus.err), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
